lifo_stack: RTL and testbench
=============================

# lifo_stack

Parametrised hardware LIFO stack for the datapath: generalised width and depth, occupancy count, full/empty flags, registered pop data with a valid strobe, overflow/underflow error pulses, same-cycle push+pop (swap), and synchronous flush. It is the standard return-address and operand stack of the processor designs, sitting between the control unit and the register/ALU datapath.

## Interface

Parameters:

- WIDTH, 12, data word width in bits (≥1)
- DEPTH, 8, number of entries (≥2, any integer, not restricted to powers of two)
- CNT_W, $clog2(DEPTH+1), derived width of count; not to be overridden

Ports:

- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  asynchronous, active-low reset; assertion clears state immediately, deassertion is synchronous to clk
- clear  input  1  synchronous flush
- push  input  1  push request
- pop  input  1  pop request
- din  input  WIDTH  data to push
- dout  output  WIDTH  registered popped data
- dout_valid  output  1  one-cycle strobe; dout was updated by the previous edge
- top  output  WIDTH  combinational peek of current top entry; 0 when empty
- count  output  CNT_W  number of stored entries, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  one-cycle pulse: push rejected
- underflow  output  1  one-cycle pulse: pop rejected

## Operation

- Storage: DEPTH × WIDTH register array, not reset; count is also the write pointer (next free slot). The top entry is at index count−1.
- Priority, evaluated per rising edge: clear > push+pop > push > pop.
- clear=1: count←0; push and pop are ignored; dout holds; dout_valid←0; overflow←0; underflow←0.
- push=1, pop=0:
  - If not full: mem[count]←din, count←count+1.
  - If full: data is dropped, count holds, overflow←1.
- pop=1, push=0:
  - If not empty: dout←mem[count−1], count←count−1, dout_valid←1.
  - If empty: dout holds, dout_valid←0, underflow←1.
- push=1, pop=1 (swap):
  - If not empty (including full): dout←mem[count−1], mem[count−1]←din, count unchanged, dout_valid←1, no error pulse.
  - If empty: pass-through. dout←din, dout_valid←1, count stays 0, no error pulse.
- Idle (push=0, pop=0): dout holds, dout_valid←0, overflow←0, underflow←0.
- overflow, underflow and dout_valid are registered and pulse for exactly one cycle per qualifying request. Back-to-back qualifying requests keep them high on consecutive cycles.
- top, empty and full are combinational from count and the array.
- Count arithmetic is CNT_W bits wide and never wraps: it saturates at 0 and DEPTH by construction.

## Timing

- Reset values: count=0, empty=1, full=0, dout=0, dout_valid=0, overflow=0, underflow=0, top=0. Array contents are undefined.
- Reset asserted mid-operation aborts any in-flight push or pop. The first accepted request is on the first rising edge after deassertion.
- Push latency: the entry is visible on top and count one cycle after the push edge.
- Pop latency: dout and dout_valid are valid the cycle after the pop edge; count decrements on the same edge.
- Swap: the old top appears on dout and the new top on the top output, both in the cycle after the edge.
- No handshake backpressure: requests are single-cycle and fire-and-forget. The requester must sample full/empty to avoid errors.

## Test plan

- Reset and fill (WIDTH=12, DEPTH=8): push 0x001..0x008 -> count=8, full=1, top=0x008. A 9th push of 0x0FF -> overflow pulses one cycle, top stays 0x008.
- Drain: pop ×8 -> dout sequence 0x008..0x001, each with dout_valid=1, empty=1 after the last pop. A 9th pop -> underflow pulses, dout holds 0x001, dout_valid=0.
- Swap: stack [0x0A,0x0B], push+pop with din=0x0C -> dout=0x0B, top=0x0C, count=2. Swap when full -> no overflow, count=8. Swap when empty with din=0x123 -> dout=0x123, dout_valid=1, count=0.
- Clear: count=5, assert clear together with push=1 -> count=0, empty=1, no overflow, dout unchanged.
- Async reset: assert rst low between clock edges while count=3 -> count=0 and all outputs at reset values immediately. Push 0x777 on the first edge after release -> top=0x777, count=1.
- Non-power-of-two DEPTH=5, WIDTH=4: push ×5 -> full=1, count=5 (CNT_W=3). Pop ×5 -> LIFO order, empty=1.

Source files
------------

// File: rtl/lifo_stack.sv
// lifo_stack: parametrised LIFO with occupancy count, full/empty flags,
// registered pop data with a valid strobe, overflow/underflow pulses,
// same-cycle push+pop swap and synchronous flush.
module lifo_stack #(
    parameter int WIDTH = 12,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic [WIDTH-1:0] top,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic             full,
    output logic             overflow,
    output logic             underflow
);

    // Storage array; contents are deliberately left unreset.
    logic [WIDTH-1:0] mem [DEPTH];

    logic [CNT_W-1:0] count_reg, count_next;
    logic [WIDTH-1:0] dout_reg, dout_next;
    logic             dout_valid_reg, dout_valid_next;
    logic             overflow_reg, overflow_next;
    logic             underflow_reg, underflow_next;

    logic [CNT_W-1:0] top_idx;
    logic [CNT_W-1:0] wr_idx;
    logic             wr_en;
    logic             empty_w;
    logic             full_w;
    logic [WIDTH-1:0] top_data;

    // count doubles as the write pointer; the top entry sits one below it.
    assign empty_w  = (count_reg == '0);
    assign full_w   = (count_reg == CNT_W'(DEPTH));
    assign top_idx  = count_reg - CNT_W'(1);
    assign top_data = empty_w ? '0 : mem[top_idx];

    // Next-state decode: clear beats swap, swap beats push, push beats pop.
    always_comb begin
        count_next      = count_reg;
        dout_next       = dout_reg;
        dout_valid_next = 1'b0;
        overflow_next   = 1'b0;
        underflow_next  = 1'b0;
        wr_en           = 1'b0;
        wr_idx          = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (push && pop) begin
            // Swap: old top leaves on dout, din replaces it. When empty the
            // word simply passes straight through to dout.
            dout_valid_next = 1'b1;
            if (empty_w) begin
                dout_next = din;
            end else begin
                dout_next = mem[top_idx];
                wr_en     = 1'b1;
                wr_idx    = top_idx;
            end
        end else if (push) begin
            if (full_w) begin
                overflow_next = 1'b1;
            end else begin
                wr_en      = 1'b1;
                count_next = count_reg + CNT_W'(1);
            end
        end else if (pop) begin
            if (empty_w) begin
                underflow_next = 1'b1;
            end else begin
                dout_next       = mem[top_idx];
                dout_valid_next = 1'b1;
                count_next      = count_reg - CNT_W'(1);
            end
        end
    end

    // Control state with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_reg      <= '0;
            dout_reg       <= '0;
            dout_valid_reg <= 1'b0;
            overflow_reg   <= 1'b0;
            underflow_reg  <= 1'b0;
        end else begin
            count_reg      <= count_next;
            dout_reg       <= dout_next;
            dout_valid_reg <= dout_valid_next;
            overflow_reg   <= overflow_next;
            underflow_reg  <= underflow_next;
        end
    end

    // One register per entry, written only when selected by wr_idx.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            // Entry gi captures din on an accepted push or swap aimed at it.
            always_ff @(posedge clk) begin
                if (wr_en && (wr_idx == CNT_W'(gi))) begin
                    mem[gi] <= din;
                end
            end
        end
    endgenerate

    assign dout       = dout_reg;
    assign dout_valid = dout_valid_reg;
    assign top        = top_data;
    assign count      = count_reg;
    assign empty      = empty_w;
    assign full       = full_w;
    assign overflow   = overflow_reg;
    assign underflow  = underflow_reg;

endmodule

// File: tb/tb_lifo_stack.sv
// Directed bench for lifo_stack: a 12x8 instance for fill/drain/swap/clear/
// reset, and a 4x5 instance for the non-power-of-two depth case.
module tb_lifo_stack;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // DEPTH=8, WIDTH=12 instance
    logic        clear = 1'b0, push = 1'b0, pop = 1'b0;
    logic [11:0] din = '0;
    logic [11:0] dout, top;
    logic [3:0]  count;
    logic        dout_valid, empty, full, overflow, underflow;

    // DEPTH=5, WIDTH=4 instance
    logic        clear5 = 1'b0, push5 = 1'b0, pop5 = 1'b0;
    logic [3:0]  din5 = '0;
    logic [3:0]  dout5, top5;
    logic [2:0]  count5;
    logic        dout_valid5, empty5, full5, overflow5, underflow5;

    int vectors = 0;
    int miscompares = 0;

    lifo_stack #(.WIDTH(12), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
        .din(din), .dout(dout), .dout_valid(dout_valid), .top(top),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
    );

    lifo_stack #(.WIDTH(4), .DEPTH(5)) dut5 (
        .clk(clk), .rst(rst), .clear(clear5), .push(push5), .pop(pop5),
        .din(din5), .dout(dout5), .dout_valid(dout_valid5), .top(top5),
        .count(count5), .empty(empty5), .full(full5),
        .overflow(overflow5), .underflow(underflow5)
    );

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, observed, expected);
        end
    endtask

    // One clock of stimulus on the 8-deep stack; returns 1ns after the edge.
    task automatic op8(input logic p, input logic q, input logic c,
                       input logic [11:0] d);
        push = p; pop = q; clear = c; din = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear = 1'b0;
        $display("d8 push=%0d pop=%0d clear=%0d din=0x%03h -> count=%0d top=0x%03h dout=0x%03h dv=%0d ovf=%0d udf=%0d",
                 p, q, c, d, count, top, dout, dout_valid, overflow, underflow);
    endtask

    task automatic op5(input logic p, input logic q, input logic [3:0] d);
        push5 = p; pop5 = q; din5 = d;
        @(posedge clk);
        #1;
        push5 = 1'b0; pop5 = 1'b0;
        $display("d5 push=%0d pop=%0d din=0x%0h -> count=%0d top=0x%0h dout=0x%0h dv=%0d",
                 p, q, d, count5, top5, dout5, dout_valid5);
    endtask

    initial begin
        // Reset values
        @(posedge clk);
        #1;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_full", 32'(full), 0);
        check("rst_dout", 32'(dout), 0);
        check("rst_dv", 32'(dout_valid), 0);
        check("rst_ovf", 32'(overflow), 0);
        check("rst_udf", 32'(underflow), 0);
        check("rst_top", 32'(top), 0);
        rst = 1'b1;

        // Fill 0x001..0x008
        for (int i = 1; i <= 8; i++) begin
            op8(1, 0, 0, 12'(i));
            check("fill_count", 32'(count), 32'(i));
            check("fill_top", 32'(top), 32'(i));
        end
        check("fill_full", 32'(full), 1);
        op8(1, 0, 0, 12'h0FF);
        check("ovf_pulse", 32'(overflow), 1);
        check("ovf_top", 32'(top), 32'h008);
        check("ovf_count", 32'(count), 8);
        op8(0, 0, 0, 12'h000);
        check("ovf_drop", 32'(overflow), 0);

        // Drain in LIFO order
        for (int i = 8; i >= 1; i--) begin
            op8(0, 1, 0, 12'h000);
            check("drain_dout", 32'(dout), 32'(i));
            check("drain_dv", 32'(dout_valid), 1);
            check("drain_count", 32'(count), 32'(i - 1));
        end
        check("drain_empty", 32'(empty), 1);
        op8(0, 1, 0, 12'h000);
        check("udf_pulse", 32'(underflow), 1);
        check("udf_dout", 32'(dout), 32'h001);
        check("udf_dv", 32'(dout_valid), 0);
        op8(0, 0, 0, 12'h000);
        check("udf_drop", 32'(underflow), 0);

        // Swap with two entries
        op8(1, 0, 0, 12'h00A);
        op8(1, 0, 0, 12'h00B);
        op8(1, 1, 0, 12'h00C);
        check("swap_dout", 32'(dout), 32'h00B);
        check("swap_dv", 32'(dout_valid), 1);
        check("swap_top", 32'(top), 32'h00C);
        check("swap_count", 32'(count), 2);

        // Swap when full
        for (int i = 1; i <= 6; i++) op8(1, 0, 0, 12'(i));
        check("pre_full", 32'(full), 1);
        op8(1, 1, 0, 12'h055);
        check("swapf_ovf", 32'(overflow), 0);
        check("swapf_count", 32'(count), 8);
        check("swapf_dout", 32'(dout), 32'h006);
        check("swapf_top", 32'(top), 32'h055);

        // Flush, then swap on empty passes through
        op8(0, 0, 1, 12'h000);
        check("clr_count", 32'(count), 0);
        op8(1, 1, 0, 12'h123);
        check("swape_dout", 32'(dout), 32'h123);
        check("swape_dv", 32'(dout_valid), 1);
        check("swape_count", 32'(count), 0);
        check("swape_udf", 32'(underflow), 0);

        // Clear wins over push
        for (int i = 1; i <= 5; i++) op8(1, 0, 0, 12'(12'h200 + i));
        check("pre_clr_count", 32'(count), 5);
        op8(1, 0, 1, 12'h3FF);
        check("clrp_count", 32'(count), 0);
        check("clrp_empty", 32'(empty), 1);
        check("clrp_ovf", 32'(overflow), 0);
        check("clrp_dout", 32'(dout), 32'h123);
        check("clrp_dv", 32'(dout_valid), 0);
        check("clrp_top", 32'(top), 0);

        // Asynchronous reset between edges
        for (int i = 1; i <= 3; i++) op8(1, 0, 0, 12'(12'h300 + i));
        check("pre_ar_count", 32'(count), 3);
        #3 rst = 1'b0;
        #1;
        check("ar_count", 32'(count), 0);
        check("ar_empty", 32'(empty), 1);
        check("ar_top", 32'(top), 0);
        check("ar_dout", 32'(dout), 0);
        check("ar_dv", 32'(dout_valid), 0);
        #2 rst = 1'b1;
        op8(1, 0, 0, 12'h777);
        check("post_ar_top", 32'(top), 32'h777);
        check("post_ar_count", 32'(count), 1);

        // Non-power-of-two depth
        for (int i = 1; i <= 5; i++) begin
            op5(1, 0, 4'(i));
            check("d5_fill_count", 32'(count5), 32'(i));
        end
        check("d5_full", 32'(full5), 1);
        for (int i = 5; i >= 1; i--) begin
            op5(0, 1, 4'h0);
            check("d5_dout", 32'(dout5), 32'(i));
            check("d5_dv", 32'(dout_valid5), 1);
        end
        check("d5_empty", 32'(empty5), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
